// File: rtl/spi_pkg.sv
// Shared constants for the SPI target: FSM state encoding, default frame width and idle miso level.
package spi_pkg;

    localparam int unsigned DefaultWidth = 8;

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StActive = 1'b1;

    localparam logic MisoIdle = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous serial-link input, with rise/fall detection
// against the previous synchronized value.
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    // Bits [STAGES-1:0] are the synchronizer; bit STAGES holds the previous synchronized value.
    logic [STAGES:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {(STAGES + 1){RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-1:0], din};
        end
    end

    assign rise = sync_q[STAGES-1] & ~sync_q[STAGES];
    assign fall = ~sync_q[STAGES-1] & sync_q[STAGES];

endmodule

// File: rtl/spi_slave.sv
// SPI target: samples sclk/ss/mosi in the clk domain and exchanges WIDTH-bit frames MSB-first.
// The master drives data on sclk fall and samples on sclk rise.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH       = DefaultWidth,
    parameter logic        SS_ACTIVE   = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             underrun,
    output logic             frame_err
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic                   ss_assert, ss_deassert, mosi_s, load;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [0:0]             state_q, state_d;
    logic [CntW-1:0]        bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0]       rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic [WIDTH-1:0]       tx_shift_q, tx_shift_d, hold_q, hold_d;
    logic                   rx_valid_q, rx_valid_d, underrun_q, underrun_d;
    logic                   frame_err_q, frame_err_d, full_q, full_d;
    logic                   reload_q, reload_d, armed_q, armed_d;

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // ss resets to the selected level, so a frame still in flight at reset release
    // yields no assert edge; the slave arms only once it sees ss go inactive.
    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (SS_ACTIVE)
    ) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ss),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    assign ss_assert   = SS_ACTIVE ? ss_rise : ss_fall;
    assign ss_deassert = SS_ACTIVE ? ss_fall : ss_rise;
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        full_d      = full_q;
        reload_d    = reload_q;
        armed_d     = armed_q | ss_deassert;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;
        load        = 1'b0;

        case (state_q)
            StIdle: begin
                if (ss_assert && armed_q) begin
                    state_d    = StActive;
                    bitcnt_d   = '0;
                    rx_shift_d = '0;
                    reload_d   = 1'b0;
                    load       = 1'b1;
                end
            end
            StActive: begin
                // ss deassert takes priority over a coincident sclk edge.
                if (ss_deassert) begin
                    frame_err_d = (bitcnt_q != '0);
                    state_d     = StIdle;
                    bitcnt_d    = '0;
                    reload_d    = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
                    if (bitcnt_q == CntW'(WIDTH - 1)) begin
                        rx_data_d  = {rx_shift_q[WIDTH-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                        bitcnt_d   = '0;
                        reload_d   = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + CntW'(1);
                    end
                end else if (sclk_fall) begin
                    if (reload_q) begin
                        load     = 1'b1;
                        reload_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A load sees the buffer as it was before any write accepted this cycle.
        if (load) begin
            if (full_q) begin
                tx_shift_d = hold_q;
                full_d     = 1'b0;
            end else begin
                tx_shift_d = '0;
                underrun_d = 1'b1;
            end
        end
        if (tx_valid && !full_q) begin
            hold_d = tx_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_sync_q <= '0;
            state_q     <= StIdle;
            bitcnt_q    <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            full_q      <= 1'b0;
            reload_q    <= 1'b0;
            armed_q     <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            full_q      <= full_d;
            reload_q    <= reload_d;
            armed_q     <= armed_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso      = (state_q == StActive) ? tx_shift_q[WIDTH-1] : MisoIdle;
    assign tx_ready  = ~full_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign underrun  = underrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural SPI master plus a queue model of the tx holding buffer.
module tb_spi_slave;

    localparam int HALF = 8;
    localparam int SYNC = 2;

    logic       clk = 1'b0, rst = 1'b0, sclk = 1'b0, ss = 1'b0, mosi = 1'b0, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, tx_ready, rx_valid, underrun, frame_err;
    logic [7:0] rx_data;

    int errors = 0, checks = 0;
    int rx_cnt = 0, ur_cnt = 0, fe_cnt = 0, cyc = 0, rise_cyc = 0, rxv_cyc = 0;
    logic [7:0] last_rx = 8'h00;
    logic [7:0] txq[$];

    spi_slave #(
        .WIDTH       (8),
        .SS_ACTIVE   (1'b1),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .ss        (ss),
        .mosi      (mosi),
        .miso      (miso),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .underrun  (underrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid) begin
                rx_cnt++;
                rxv_cyc = cyc;
            end
            if (underrun) ur_cnt++;
            if (frame_err) fe_cnt++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master: mosi changes at entry (ss assert or sclk fall), slave sampled on each rise.
    task automatic shift_bits(input logic [7:0] out, input int nbits, input bit hold_clk,
                              output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = out[7-i];
            wait_clk(HALF);
            sclk     = 1'b1;
            rise_cyc = cyc;
            got      = {got[6:0], miso};
            wait_clk(HALF);
            if (i < nbits - 1 || !hold_clk) sclk = 1'b0;
        end
    endtask

    // Ends a frame by dropping ss together with the trailing sclk fall.
    task automatic frame_end();
        sclk = 1'b0;
        ss   = 1'b0;
        mosi = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic tx_write(input logic [7:0] d);
        int n = 0;
        while (!tx_ready && n < 200) begin
            wait_clk(1);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL tx_ready_timeout: tx_ready=%b after %0d cycles, required 1", tx_ready, n);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL tx_ready_after_write: got %b expected 0", tx_ready);
        end
    endtask

    task automatic test_reset();
        logic [12:0] exp_rst = {5'b00100, 8'h00};
        rst = 1'b0;
        wait_clk(3);
        checks++;
        if ({miso, rx_valid, tx_ready, underrun, frame_err, rx_data} !== exp_rst) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h",
                     {miso, rx_valid, tx_ready, underrun, frame_err, rx_data}, exp_rst);
        end
        rst = 1'b1;
        wait_clk(6);
        checks++;
        if ({miso, rx_valid, tx_ready, underrun, frame_err, rx_data} !== exp_rst) begin
            errors++;
            $display("FAIL post_reset_idle: got %h expected %h",
                     {miso, rx_valid, tx_ready, underrun, frame_err, rx_data}, exp_rst);
        end
    endtask

    task automatic test_basic();
        logic [7:0] got;
        int rb = rx_cnt, ub = ur_cnt;
        tx_write(8'h37);
        ss = 1'b1;
        shift_bits(8'h13, 8, 1'b1, got);
        frame_end();
        last_rx = 8'h13;
        checks++;
        if (got !== 8'h37) begin errors++; $display("FAIL basic_miso: got %h expected 37", got); end
        checks++;
        if (rx_data !== 8'h13) begin errors++; $display("FAIL basic_rx: got %h expected 13", rx_data); end
        checks++;
        if (rx_cnt - rb != 1) begin errors++; $display("FAIL basic_rx_pulses: got %0d expected 1", rx_cnt - rb); end
        checks++;
        if (rxv_cyc - rise_cyc != SYNC + 1) begin
            errors++;
            $display("FAIL basic_rx_latency: got %0d expected %0d", rxv_cyc - rise_cyc, SYNC + 1);
        end
        checks++;
        if (ur_cnt != ub || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_buffer: underruns %0d tx_ready %b, expected 0 and 1", ur_cnt - ub, tx_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] g1, g2, g3;
        int rb = rx_cnt, ub = ur_cnt;
        tx_write(8'hA5);
        ss = 1'b1;
        shift_bits(8'h01, 4, 1'b0, g1);
        tx_write(8'h5A);
        shift_bits(8'h01 << 4, 4, 1'b0, g2);
        checks++;
        if (rx_data !== 8'h01) begin errors++; $display("FAIL b2b_rx1: got %h expected 01", rx_data); end
        shift_bits(8'h02, 8, 1'b1, g3);
        frame_end();
        last_rx = 8'h02;
        checks++;
        if ({g1[3:0], g2[3:0]} !== 8'hA5) begin
            errors++;
            $display("FAIL b2b_miso1: got %h expected a5", {g1[3:0], g2[3:0]});
        end
        checks++;
        if (g3 !== 8'h5A) begin errors++; $display("FAIL b2b_miso2: got %h expected 5a", g3); end
        checks++;
        if (rx_data !== 8'h02 || rx_cnt - rb != 2) begin
            errors++;
            $display("FAIL b2b_rx2: got %h/%0d pulses expected 02/2", rx_data, rx_cnt - rb);
        end
        checks++;
        if (ur_cnt != ub) begin errors++; $display("FAIL b2b_underrun: got %0d expected 0", ur_cnt - ub); end
    endtask

    task automatic test_underrun();
        logic [7:0] got;
        int ub = ur_cnt;
        ss = 1'b1;
        shift_bits(8'hFF, 8, 1'b1, got);
        frame_end();
        last_rx = 8'hFF;
        checks++;
        if (got !== 8'h00) begin errors++; $display("FAIL ur_miso: got %h expected 00", got); end
        checks++;
        if (ur_cnt - ub != 1) begin errors++; $display("FAIL ur_pulses: got %0d expected 1", ur_cnt - ub); end
        checks++;
        if (rx_data !== 8'hFF) begin errors++; $display("FAIL ur_rx: got %h expected ff", rx_data); end
    endtask

    task automatic test_frame_err();
        logic [7:0] got;
        int rb = rx_cnt, fb = fe_cnt;
        ss = 1'b1;
        shift_bits(8'($urandom), 4, 1'b1, got);
        frame_end();
        checks++;
        if (fe_cnt - fb != 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - fb); end
        checks++;
        if (rx_cnt != rb || rx_data !== last_rx) begin
            errors++;
            $display("FAIL ferr_rx_kept: got %h/%0d pulses expected %h/0", rx_data, rx_cnt - rb, last_rx);
        end
        ss = 1'b1;
        shift_bits(8'hC3, 8, 1'b1, got);
        frame_end();
        last_rx = 8'hC3;
        checks++;
        if (rx_data !== 8'hC3 || fe_cnt - fb != 1) begin
            errors++;
            $display("FAIL ferr_recover: got %h/%0d errs expected c3/1", rx_data, fe_cnt - fb);
        end
    endtask

    task automatic test_load_collision();
        logic [7:0] got;
        int ub = ur_cnt;
        ss   = 1'b1;
        mosi = 1'b0;
        wait_clk(SYNC);
        tx_data  = 8'h5C;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        checks++;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL coll_held: tx_ready %b expected 0", tx_ready); end
        shift_bits(8'h3C, 8, 1'b1, got);
        frame_end();
        checks++;
        if (got !== 8'h00 || ur_cnt - ub != 1) begin
            errors++;
            $display("FAIL coll_frame1: got %h/%0d underruns expected 00/1", got, ur_cnt - ub);
        end
        ss = 1'b1;
        shift_bits(8'h66, 8, 1'b1, got);
        frame_end();
        last_rx = 8'h66;
        checks++;
        if (got !== 8'h5C || ur_cnt - ub != 1) begin
            errors++;
            $display("FAIL coll_frame2: got %h/%0d underruns expected 5c/1", got, ur_cnt - ub);
        end
    endtask

    task automatic test_random();
        logic [7:0] got, txw, rxw, exp_tx;
        int rb, ub;
        bit exp_ur;
        for (int f = 0; f < 6; f++) begin
            txw = 8'($urandom);
            rxw = 8'($urandom);
            rb  = rx_cnt;
            ub  = ur_cnt;
            if ($urandom_range(0, 1) == 1) begin
                txq.push_back(txw);
                tx_write(txw);
            end
            exp_ur = (txq.size() == 0);
            exp_tx = exp_ur ? 8'h00 : txq.pop_front();
            ss = 1'b1;
            shift_bits(rxw, 8, 1'b1, got);
            frame_end();
            last_rx = rxw;
            checks++;
            if (got !== exp_tx || rx_data !== rxw) begin
                errors++;
                $display("FAIL rand_frame%0d: miso %h rx %h expected %h %h", f, got, rx_data, exp_tx, rxw);
            end
            checks++;
            if (rx_cnt - rb != 1 || ur_cnt - ub != int'(exp_ur)) begin
                errors++;
                $display("FAIL rand_pulses%0d: rx %0d ur %0d expected 1 %0d", f, rx_cnt - rb, ur_cnt - ub, exp_ur);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] got, txw;
        logic [12:0] exp_rst = {5'b00100, 8'h00};
        int rb, ub, fb;
        ss = 1'b1;
        shift_bits(8'hE7, 5, 1'b1, got);
        tx_write(8'h99);
        rst = 1'b0;
        #1;
        checks++;
        if ({miso, rx_valid, tx_ready, underrun, frame_err, rx_data} !== exp_rst) begin
            errors++;
            $display("FAIL midreset_values: got %h expected %h",
                     {miso, rx_valid, tx_ready, underrun, frame_err, rx_data}, exp_rst);
        end
        wait_clk(3);
        rst = 1'b1;
        rb  = rx_cnt;
        ub  = ur_cnt;
        fb  = fe_cnt;
        wait_clk(4);
        sclk = 1'b0;
        shift_bits(8'hE7 << 5, 3, 1'b1, got);
        frame_end();
        checks++;
        if (rx_cnt != rb || ur_cnt != ub || fe_cnt != fb || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL midreset_ignored: rx %0d ur %0d fe %0d data %h expected 0 0 0 00",
                     rx_cnt - rb, ur_cnt - ub, fe_cnt - fb, rx_data);
        end
        txw = 8'($urandom);
        tx_write(txw);
        ss = 1'b1;
        shift_bits(8'h81, 8, 1'b1, got);
        frame_end();
        checks++;
        if (rx_data !== 8'h81 || got !== txw || rx_cnt - rb != 1) begin
            errors++;
            $display("FAIL midreset_next: rx %h miso %h pulses %0d expected 81 %h 1", rx_data, got, rx_cnt - rb, txw);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        wait_clk(1);
        test_reset();
        test_basic();
        test_back_to_back();
        test_underrun();
        test_frame_err();
        test_load_collision();
        test_random();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
